// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W      = 32;
    localparam int unsigned FETCH_DATA_W      = 32;
    localparam int unsigned FETCH_INSTR_BYTES = 4;
    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_FULL  = 3'd2,
        S_DROP  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response and decode valid/ready bundle.
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
);
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemAck;
    logic [DATA_W-1:0] MemRdata;
    logic              InstrValid;
    logic [DATA_W-1:0] Instruction;
    logic [ADDR_W-1:0] InstrPC;
    logic              DecodeReady;

    modport master (
        output MemReq, MemAddr, InstrValid, Instruction, InstrPC,
        input  MemAck, MemRdata, DecodeReady
    );

    modport slave (
        input  MemReq, MemAddr, InstrValid, Instruction, InstrPC,
        output MemAck, MemRdata, DecodeReady
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC mux: reset vector, branch redirect, sequential advance, or hold.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = FETCH_ADDR_W,
    parameter int unsigned       INSTR_BYTES  = FETCH_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(FETCH_RESET_VECTOR)
) (
    input  logic              Reset,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic [ADDR_W-1:0] PCResult,
    input  logic              Advance,
    output logic [ADDR_W-1:0] Address
);

    // Increment wraps naturally at 2^ADDR_W.
    always_comb begin
        Address = PCResult;
        if (!Reset) begin
            Address = RESET_VECTOR;
        end else if (BranchTaken) begin
            Address = BranchTarget;
        end else if (Advance) begin
            Address = PCResult + ADDR_W'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM: one outstanding instruction-memory read, delivers words to decode.
// Optional misaligned-fetch trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = FETCH_ADDR_W,
    parameter int unsigned       DATA_W       = FETCH_DATA_W,
    parameter int unsigned       INSTR_BYTES  = FETCH_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(FETCH_RESET_VECTOR)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PCResult,
    output logic [ADDR_W-1:0] Address,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    fetch_sequencer_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              FetchFault
`endif
);

    fetch_state_e      state;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              instr_valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              advance_c;
    logic              enter_req_c;
    logic              misalign_c;

    assign advance_c = (state == S_REQ) && bus.MemAck;

    fetch_next_pc #(
        .ADDR_W       (ADDR_W),
        .INSTR_BYTES  (INSTR_BYTES),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_next_pc (
        .Reset        (Reset),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .PCResult     (PCResult),
        .Advance      (advance_c),
        .Address      (Address)
    );

    // Conditions under which a fresh request is launched at Address.
    always_comb begin
        enter_req_c = 1'b0;
        case (state)
            S_IDLE:  enter_req_c = 1'b1;
            S_REQ:   enter_req_c = bus.MemAck && BranchTaken;
            S_FULL:  enter_req_c = BranchTaken || bus.DecodeReady;
            S_DROP:  enter_req_c = bus.MemAck;
            S_FAULT: enter_req_c = BranchTaken;
            default: enter_req_c = 1'b0;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    assign misalign_c = |Address[1:0];
    assign FetchFault = fault_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fault_q <= 1'b0;
        end else if (enter_req_c) begin
            fault_q <= misalign_c;
        end
    end
`else
    assign misalign_c = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else if (enter_req_c) begin
            instr_valid_q <= 1'b0;
            if (misalign_c) begin
                state     <= S_FAULT;
                mem_req_q <= 1'b0;
            end else begin
                state      <= S_REQ;
                mem_req_q  <= 1'b1;
                mem_addr_q <= Address;
            end
        end else if (state == S_REQ) begin
            if (bus.MemAck) begin
                state         <= S_FULL;
                mem_req_q     <= 1'b0;
                instr_valid_q <= 1'b1;
                instr_q       <= bus.MemRdata;
                instr_pc_q    <= mem_addr_q;
            end else if (BranchTaken) begin
                // Request stays on the bus; its response will be discarded.
                state <= S_DROP;
            end
        end
    end

    assign bus.MemReq      = mem_req_q;
    assign bus.MemAddr     = mem_addr_q;
    assign bus.InstrValid  = instr_valid_q;
    assign bus.Instruction = instr_q;
    assign bus.InstrPC     = instr_pc_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the program counter's next-address input and consumes its current value.
- Computes `Address` from `PCResult` (hold / +4 / branch redirect).
- Issues one-outstanding read requests to instruction memory and presents each fetched word, with its PC, to decode via a valid/ready handshake.
- Sits between the program counter register and the instruction memory in the instruction fetch unit.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, instruction word width
- INSTR_BYTES, 4, PC increment per instruction
- RESET_VECTOR, 32'h0000_0000, value driven on Address while Reset is low

Ports:
- Clk  in  1  single clock; all state updates on posedge
- Reset  in  1  synchronous, active-low reset
- PCResult  in  ADDR_W  current PC from program counter
- Address  out  ADDR_W  next PC to program counter (combinational)
- BranchTaken  in  1  redirect pulse from execute
- BranchTarget  in  ADDR_W  redirect address, valid with BranchTaken
- MemReq  out  1  read request to instruction memory (registered)
- MemAddr  out  ADDR_W  request address (registered, stable while MemReq=1)
- MemAck  in  1  one-cycle response strobe; MemRdata valid that cycle
- MemRdata  in  DATA_W  fetched word
- InstrValid  out  1  Instruction/InstrPC valid to decode
- Instruction  out  DATA_W  fetched word
- InstrPC  out  ADDR_W  PC of Instruction
- DecodeReady  in  1  decode accepts when InstrValid & DecodeReady

Behaviour:
- Reset (Reset=0 at posedge): state=S_IDLE; MemReq=0; MemAddr=0; InstrValid=0; Instruction=0; InstrPC=0. While Reset=0, Address=RESET_VECTOR.
- Address, with priority in this order:
  - BranchTarget if BranchTaken;
  - else PCResult+INSTR_BYTES if state=S_REQ & MemAck;
  - else PCResult.
  - Increment is modulo 2^ADDR_W: 32'hFFFF_FFFC -> 0.
- "Enter S_REQ" always means MemAddr<=Address and MemReq<=1 at the same edge.
- MemReq=1 in S_REQ and S_DROP only. Memory contract: once MemReq=1, MemAddr is unchanged until the MemAck cycle.
- S_IDLE: unconditionally enter S_REQ next edge. First request is issued 1 cycle after reset release.
- S_REQ:
  - MemAck & !BranchTaken: capture Instruction<=MemRdata, InstrPC<=MemAddr, InstrValid<=1; go S_FULL (PC advances same edge).
  - MemAck & BranchTaken: discard data; re-enter S_REQ at BranchTarget.
  - BranchTaken & !MemAck: go S_DROP.
  - Otherwise hold.
- S_FULL (InstrValid=1; outputs held stable):
  - BranchTaken: InstrValid<=0; enter S_REQ at BranchTarget (wins over DecodeReady).
  - DecodeReady: InstrValid<=0; enter S_REQ at PCResult.
  - Otherwise hold.
- S_DROP (stale request in flight):
  - MemAck: discard data; enter S_REQ at Address, which is BranchTarget if BranchTaken, else PCResult.
  - No MemAck: hold. A further BranchTaken only updates the PC via Address.
- Latency and throughput:
  - Minimum 2 cycles from request to InstrValid (ack in the first S_REQ cycle).
  - Peak throughput 1 instruction per 2 cycles.
- Reset mid-operation: an outstanding request is abandoned. Any MemAck arriving while Reset=0 or in S_IDLE is ignored.
- No instruction is ever delivered for a PC that was redirected away from.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output FetchFault (1 bit, reset 0).
  - On entering S_REQ with Address[1:0]!=0: no request is issued; state goes S_FAULT with FetchFault=1 and MemReq=0; Address holds PCResult.
  - Only Reset or BranchTaken exits S_FAULT. BranchTaken enters S_REQ at BranchTarget and clears FetchFault.
- Undefined: no FetchFault port; low address bits pass through unchecked.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding typedef (S_IDLE, S_REQ, S_FULL, S_DROP, S_FAULT);
  - INSTR_BYTES;
  - RESET_VECTOR default.
- Natural sub-module: fetch_next_pc, the combinational Address mux/incrementer. The FSM and output register stay in fetch_sequencer.

Test Plan:
- Reset release, PCResult=0, memory acks 1 cycle after MemReq with 32'h2002_0001 -> MemAddr=0; InstrValid=1, Instruction=32'h2002_0001, InstrPC=0; Address=4 on ack cycle.
- DecodeReady held 0 for 5 cycles in S_FULL -> InstrValid, Instruction, InstrPC stable; Address=PCResult=4; MemReq=0.
- BranchTaken with target 32'h40 while request to 8 is pending (ack 3 cycles later) -> S_DROP; stale data discarded; next MemAddr=32'h40; InstrPC=32'h40.
- BranchTaken and DecodeReady together in S_FULL -> InstrValid falls; next MemAddr=BranchTarget.
- PCResult=32'hFFFF_FFFC fetch acked -> Address=0; next MemAddr=0.
- With FETCH_MISALIGN_TRAP_EN, BranchTarget=32'h42 -> FetchFault=1, MemReq stays 0; BranchTarget=32'h44 -> FetchFault=0, MemAddr=32'h44.
